// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midi_pkg
//  Description : Shared types and constants for the MIDI channel-message
//                parser: FSM state type, byte-class type, byte-class range
//                boundaries and the channel-message length function.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

    // Parser FSM states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA1 = 2'd1,
        ST_DATA2 = 2'd2
    } state_t;

    // Classification of a received byte
    typedef enum logic [1:0] {
        CLS_DATA   = 2'd0,
        CLS_CHAN   = 2'd1,
        CLS_SYSCOM = 2'd2,
        CLS_RT     = 2'd3
    } byte_class_t;

    // Lower bounds of the byte-class ranges
    localparam logic [7:0] c_CHAN_BASE   = 8'h80;  // channel messages start
    localparam logic [7:0] c_LEN1_BASE   = 8'hC0;  // program change / aftertouch
    localparam logic [7:0] c_PBEND_BASE  = 8'hE0;  // pitch bend (back to 2 bytes)
    localparam logic [7:0] c_SYSCOM_BASE = 8'hF0;  // system common
    localparam logic [7:0] c_RT_BASE     = 8'hF8;  // realtime

    // Number of data bytes following a channel status byte
    function automatic logic [1:0] msg_len(input logic [7:0] status);
        if ((status >= c_LEN1_BASE) && (status < c_PBEND_BASE)) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_status_decode.sv
`default_nettype none
// ============================================================================
//  Module      : midi_status_decode
//  Description : Purely combinational classifier for one received MIDI byte.
//  Ports       : i_byte  - byte to classify
//                o_class - data / channel status / system common / realtime
//                o_len   - data byte count for channel status bytes, else 0
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_status_decode
    import midi_pkg::*;
(
    input  logic [7:0]  i_byte,
    output byte_class_t o_class,
    output logic [1:0]  o_len
);

    always_comb begin
        o_class = CLS_DATA;
        o_len   = 2'd0;
        if (i_byte >= c_RT_BASE) begin
            o_class = CLS_RT;
        end else if (i_byte >= c_SYSCOM_BASE) begin
            o_class = CLS_SYSCOM;
        end else if (i_byte >= c_CHAN_BASE) begin
            o_class = CLS_CHAN;
            o_len   = msg_len(i_byte);
        end
    end

endmodule
`default_nettype wire

// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
//  Module      : midi_msg_parser
//  Description : Assembles MIDI channel messages (0x80-0xEF plus 1 or 2 data
//                bytes) from a byte stream and presents them on a
//                valid/ready output with a one-deep holding register.
//                Realtime bytes are transparent; system common bytes abort
//                the message in progress.
//  Config      : MIDI_RUNNING_STATUS_EN - when defined, the status byte is
//                retained after a message completes so that further data
//                bytes form new messages (running status).
//  Ports       : clk        - system clock, rising edge
//                rst_n      - synchronous active-low reset
//                byte_valid - one-cycle strobe for byte_data
//                byte_data  - received MIDI byte
//                msg_ready  - downstream accepts the pending message
//                msg_valid  - message pending on msg_status/msg_data1/2
//                msg_status - status byte of the pending message
//                msg_data1  - first data byte
//                msg_data2  - second data byte (0 for one-byte messages)
//                overrun    - one-cycle pulse when a message was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_msg_parser
    import midi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       msg_ready,
    output logic       msg_valid,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       overrun
);

`ifdef MIDI_RUNNING_STATUS_EN
    localparam logic c_RUNNING_STATUS = 1'b1;
`else
    localparam logic c_RUNNING_STATUS = 1'b0;
`endif

    byte_class_t w_class;
    logic [1:0]  w_len;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cur_status, w_cur_status_nxt;  // 0 means "no status"
    logic [1:0]  r_cur_len, w_cur_len_nxt;
    logic [6:0]  r_part_d1, w_part_d1_nxt;

    logic        w_done;
    logic        w_take_d1;
    logic [6:0]  w_done_d1;
    logic [6:0]  w_done_d2;

    logic        r_msg_valid;
    logic [7:0]  r_msg_status;
    logic [6:0]  r_msg_data1;
    logic [6:0]  r_msg_data2;
    logic        r_overrun;

    midi_status_decode u_decode (
        .i_byte  (byte_data),
        .o_class (w_class),
        .o_len   (w_len)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cur_status <= 8'h00;
            r_cur_len    <= 2'd0;
            r_part_d1    <= 7'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_status <= w_cur_status_nxt;
            r_cur_len    <= w_cur_len_nxt;
            r_part_d1    <= w_part_d1_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / assembly logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cur_status_nxt = r_cur_status;
        w_cur_len_nxt    = r_cur_len;
        w_part_d1_nxt    = r_part_d1;
        w_done           = 1'b0;
        w_done_d1        = 7'd0;
        w_done_d2        = 7'd0;
        // A data byte in IDLE only counts as data1 under running status,
        // and only while a status is still held (bit 7 set).
        w_take_d1        = (r_state == ST_DATA1) ||
                           (c_RUNNING_STATUS && (r_state == ST_IDLE) &&
                            r_cur_status[7]);

        if (byte_valid) begin
            unique case (w_class)
                CLS_CHAN: begin
                    w_cur_status_nxt = byte_data;
                    w_cur_len_nxt    = w_len;
                    w_part_d1_nxt    = 7'd0;
                    w_state_nxt      = ST_DATA1;
                end
                CLS_SYSCOM: begin
                    w_cur_status_nxt = 8'h00;
                    w_cur_len_nxt    = 2'd0;
                    w_part_d1_nxt    = 7'd0;
                    w_state_nxt      = ST_IDLE;
                end
                CLS_RT: begin
                    // transparent: nothing changes
                end
                default: begin
                    if (w_take_d1) begin
                        if (r_cur_len == 2'd2) begin
                            w_part_d1_nxt = byte_data[6:0];
                            w_state_nxt   = ST_DATA2;
                        end else begin
                            w_done    = 1'b1;
                            w_done_d1 = byte_data[6:0];
                        end
                    end else if (r_state == ST_DATA2) begin
                        w_done    = 1'b1;
                        w_done_d1 = r_part_d1;
                        w_done_d2 = byte_data[6:0];
                    end
                    if (w_done) begin
                        w_state_nxt   = ST_IDLE;
                        w_part_d1_nxt = 7'd0;
                        if (!c_RUNNING_STATUS) begin
                            w_cur_status_nxt = 8'h00;
                            w_cur_len_nxt    = 2'd0;
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output holding register. A completion landing in the same cycle as
    // acceptance replaces the message and keeps valid high; a completion
    // while the held message is stalled is dropped and flagged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_msg_valid  <= 1'b0;
            r_msg_status <= 8'h00;
            r_msg_data1  <= 7'd0;
            r_msg_data2  <= 7'd0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_msg_valid || msg_ready) begin
                    r_msg_valid  <= 1'b1;
                    r_msg_status <= r_cur_status;
                    r_msg_data1  <= w_done_d1;
                    r_msg_data2  <= w_done_d2;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_msg_valid && msg_ready) begin
                r_msg_valid <= 1'b0;
            end
        end
    end

    assign msg_valid  = r_msg_valid;
    assign msg_status = r_msg_status;
    assign msg_data1  = r_msg_data1;
    assign msg_data2  = r_msg_data2;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_midi_msg_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_midi_msg_parser
//  Description : Directed self-checking bench for midi_msg_parser. Expected
//                values are hand-computed; running-status expectations
//                follow MIDI_RUNNING_STATUS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_msg_parser;

    logic       clk;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       msg_ready;
    logic       msg_valid;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic       overrun;

    int total;
    int bad;

    midi_msg_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .msg_ready  (msg_ready),
        .msg_valid  (msg_valid),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_msg(input string tag, input logic v, input logic [7:0] s,
                             input logic [7:0] d1, input logic [7:0] d2);
        check({tag, ".valid"},  {7'd0, msg_valid}, {7'd0, v});
        check({tag, ".status"}, msg_status, s);
        check({tag, ".d1"},     {1'b0, msg_data1}, d1);
        check({tag, ".d2"},     {1'b0, msg_data2}, d2);
    endtask

    // Byte is sampled on the posedge after the first negedge; returns on the
    // following negedge, i.e. in the cycle after byte_valid.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        msg_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_msg("reset", 1'b0, 8'h00, 8'h00, 8'h00);
        check("reset.overrun", {7'd0, overrun}, 8'h00);

        // Note-on, latency one cycle after last data byte
        send(8'h90);
        send(8'h3C);
        check("noteon.pre_valid", {7'd0, msg_valid}, 8'h00);
        send(8'h64);
        check_msg("noteon", 1'b1, 8'h90, 8'h3C, 8'h64);
        @(negedge clk);
        check("noteon.accepted", {7'd0, msg_valid}, 8'h00);

        // One-data-byte message
        send(8'hC5);
        send(8'h07);
        check_msg("progchg", 1'b1, 8'hC5, 8'h07, 8'h00);

        // Realtime byte inside a message is transparent
        send(8'h90);
        send(8'h3C);
        send(8'hF8);
        check("rt.no_valid", {7'd0, msg_valid}, 8'h00);
        send(8'h64);
        check_msg("rt", 1'b1, 8'h90, 8'h3C, 8'h64);

        // Running status
        send(8'h90);
        send(8'h3C);
        send(8'h64);
        check_msg("rs.first", 1'b1, 8'h90, 8'h3C, 8'h64);
        send(8'h40);
        check("rs.mid", {7'd0, msg_valid}, 8'h00);
        send(8'h00);
`ifdef MIDI_RUNNING_STATUS_EN
        check_msg("rs.second", 1'b1, 8'h90, 8'h40, 8'h00);
`else
        check("rs.discard", {7'd0, msg_valid}, 8'h00);
`endif

        // New status mid-message restarts assembly
        send(8'h90);
        send(8'h3C);
        send(8'hB0);
        send(8'h07);
        send(8'h7F);
        check_msg("restart", 1'b1, 8'hB0, 8'h07, 8'h7F);

        // Back-pressure: first held, second dropped with overrun
        @(negedge clk);
        msg_ready = 1'b0;
        send(8'h80);
        send(8'h40);
        send(8'h00);
        check_msg("hold.first", 1'b1, 8'h80, 8'h40, 8'h00);
        send(8'h90);
        send(8'h45);
        send(8'h7F);
        check("hold.overrun", {7'd0, overrun}, 8'h01);
        check_msg("hold.kept", 1'b1, 8'h80, 8'h40, 8'h00);
        @(negedge clk);
        check("hold.overrun_pulse", {7'd0, overrun}, 8'h00);
        check_msg("hold.still", 1'b1, 8'h80, 8'h40, 8'h00);

        // Completion coincident with acceptance replaces the message
        send(8'hC1);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h22;
        msg_ready  = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        check_msg("swap", 1'b1, 8'hC1, 8'h22, 8'h00);
        check("swap.overrun", {7'd0, overrun}, 8'h00);
        @(negedge clk);
        check("swap.accepted", {7'd0, msg_valid}, 8'h00);

        // System common aborts message and discards following data
        send(8'h90);
        send(8'h3C);
        send(8'hF2);
        send(8'h64);
        send(8'h10);
        check("syscom.discard", {7'd0, msg_valid}, 8'h00);

        // Reset mid-message discards the partial message
        send(8'h90);
        send(8'h3C);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h64);
        check_msg("rstmid", 1'b0, 8'h00, 8'h00, 8'h00);
        check("rstmid.overrun", {7'd0, overrun}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/midi_msg_parser.md
MIDI_MSG_PARSER -- requirements
Module: midi_msg_parser

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk in 1 (system clock, all state on rising edge), rst_n in 1 (synchronous active-low reset).
REQ-002 SHALL have byte_valid in 1: one-cycle strobe marking a received MIDI byte.
REQ-003 SHALL have byte_data in 8: received byte, sampled only when byte_valid=1.
REQ-004 SHALL have msg_ready in 1: downstream accepts the message when msg_valid=1.
REQ-005 SHALL have msg_valid out 1: complete channel message available.
REQ-006 SHALL have msg_status out 8: status byte of the message (0x80-0xEF).
REQ-007 SHALL have msg_data1 out 7: first data byte.
REQ-008 SHALL have msg_data2 out 7: second data byte, 0 for one-data messages.
REQ-009 SHALL have overrun out 1: one-cycle pulse when a completed message is dropped.

Function
REQ-010 SHALL implement FSM states IDLE, DATA1, DATA2; state register plus combinational next-state.
REQ-011 SHALL classify bytes: status 0x80-0xEF (channel), 0xF0-0xF7 (system common), 0xF8-0xFF (realtime), 0x00-0x7F (data).
REQ-012 SHALL set message length: 0x80-0xBF and 0xE0-0xEF = 2 data bytes; 0xC0-0xDF = 1 data byte.
REQ-013 SHALL, on a channel status byte in any state, latch it as the current status, clear partial data, and go to DATA1.
REQ-014 SHALL, on a data byte in DATA1, latch data1; go to DATA2 if length 2, else complete the message.
REQ-015 SHALL, on a data byte in DATA2, latch data2 and complete the message.
REQ-016 SHALL, on a data byte in IDLE, handle it per REQ-027/REQ-028.
REQ-017 SHALL, on a system common byte, clear the current status, clear partial data, go to IDLE, and discard following data bytes until a channel status byte arrives.
REQ-018 SHALL ignore realtime bytes entirely: no change to state, the current status, partial data, or outputs.
REQ-019 SHALL, on completion, assert msg_valid on the cycle after the final data byte's byte_valid (latency 1), then return to IDLE.
REQ-020 SHALL hold msg_valid and msg_status/msg_data1/msg_data2 stable until the cycle msg_valid=1 and msg_ready=1, then deassert msg_valid the next cycle unless REQ-021 applies.
REQ-021 SHALL, when a completion coincides with acceptance in the same cycle, load the new message and keep msg_valid=1.
REQ-022 SHALL, when a completion occurs while msg_valid=1 and msg_ready=0, keep the pending message, drop the new one, and pulse overrun for one cycle.
REQ-023 SHALL continue assembling input bytes while a message is pending; byte_valid is never back-pressured.

Reset
REQ-024 SHALL, on rst_n=0 at a clock edge, set state=IDLE, clear the current status, msg_valid=0, msg_status=0x00, msg_data1=0, msg_data2=0, overrun=0.
REQ-025 SHALL give reset priority over byte_valid and msg_ready; a partial message in progress is discarded with no output.

Configuration
REQ-026 SHALL support macro MIDI_RUNNING_STATUS_EN.
REQ-027 SHALL, with MIDI_RUNNING_STATUS_EN defined, retain the current status after completion, so that a data byte in IDLE with a valid current status is treated as data1 (DATA1 behaviour).
REQ-028 SHALL, without MIDI_RUNNING_STATUS_EN, clear the current status on completion and discard all data bytes received in IDLE.

Structure
REQ-029 SHALL place in shared package midi_pkg: the FSM state typedef, byte-class constants (0x80, 0xC0, 0xE0, 0xF0, 0xF8), and a message-length function.
REQ-030 SHALL use one combinational sub-module, midi_status_decode: input byte, outputs byte class and data length.

Verification
REQ-031 SHALL cover: with msg_ready=1, bytes 0x90,0x3C,0x64 -> msg_valid one cycle after 0x64 with status=0x90, d1=0x3C, d2=0x64.
REQ-032 SHALL cover: bytes 0xC5,0x07 -> status=0xC5, d1=0x07, d2=0x00.
REQ-033 SHALL cover: bytes 0x90,0x3C,0xF8,0x64 -> same output as REQ-031 (realtime byte ignored).
REQ-034 SHALL cover: bytes 0x90,0x3C,0x64,0x40,0x00 -> with MIDI_RUNNING_STATUS_EN, a second message 0x90/0x40/0x00; without it, the second pair is discarded.
REQ-035 SHALL cover: msg_ready=0, two complete messages sent -> first message held, overrun pulses once, outputs unchanged.
REQ-036 SHALL cover: 0x90,0x3C, then rst_n=0 for one cycle, then 0x64 -> no msg_valid, all outputs 0.
